// File: rtl/serial_pattern_detector_if.sv
// Serial-in / match-out bundle between the upstream flip-flop stage and the pattern detector.
interface serial_pattern_detector_if #(
  parameter int CW = 8
);
  logic          D;
  logic          En;
  logic          Clear;
  logic          Valid;
  logic          Match;
  logic [CW-1:0] Count;

  modport master (output D, En, Clear, input Valid, Match, Count);
  modport slave  (input D, En, Clear, output Valid, Match, Count);
endinterface

// File: rtl/serial_pattern_detector.sv
// Shifts a registered serial bit into an N-bit history and flags/counts (overlapping)
// occurrences of a fixed pattern once N real samples have been taken since reset/clear.
module serial_pattern_detector #(
  parameter int           N       = 4,
  parameter logic [N-1:0] PATTERN = 4'b1011,
  parameter int           CW      = 8
) (
  input  logic                       Clock,
  input  logic                       Resetn,
  serial_pattern_detector_if.slave   bus
);
  localparam int FW = $clog2(N + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(N);
  localparam logic [CW-1:0] COUNT_MAX = {CW{1'b1}};

  typedef enum logic {FILLING, ARMED} state_t;

  state_t        state, state_nxt;
  logic [FW-1:0] fill, fill_nxt;
  logic [N-1:0]  hist, hist_nxt;
  logic          match, match_nxt;
  logic [CW-1:0] count, count_nxt;

  // State and datapath registers
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= FILLING;
      fill  <= '0;
      hist  <= '0;
      match <= 1'b0;
      count <= '0;
    end else begin
      state <= state_nxt;
      fill  <= fill_nxt;
      hist  <= hist_nxt;
      match <= match_nxt;
      count <= count_nxt;
    end
  end

  // Next-state: Clear outranks En; FILLING only advances on enabled edges
  always_comb begin
    state_nxt = state;
    fill_nxt  = fill;
    hist_nxt  = hist;
    if (bus.Clear) begin
      state_nxt = FILLING;
      fill_nxt  = '0;
      hist_nxt  = '0;
    end else if (bus.En) begin
      hist_nxt = {hist[N-2:0], bus.D};
      if (state == FILLING) begin
        fill_nxt = fill + FW'(1);
        if (fill_nxt == FILL_FULL) state_nxt = ARMED;
      end
    end
  end

  // Outputs: fill guard keeps zeroed history from ever matching an all-zero pattern
  always_comb begin
    match_nxt = bus.En && !bus.Clear && (fill_nxt == FILL_FULL) && (hist_nxt == PATTERN);
    count_nxt = count;
    if (bus.Clear)
      count_nxt = '0;
    else if (match_nxt && count != COUNT_MAX)
      count_nxt = count + CW'(1);
  end

  assign bus.Valid = (state == ARMED);
  assign bus.Match = match;
  assign bus.Count = count;

endmodule
